// File: rtl/core_debug_ctrl.sv
// core_debug_ctrl: run/halt/step debug controller with a probe snapshot, a display mux and a retired-instruction counter.
// The optional PC breakpoint comparator is built only when the macro DBG_BREAKPOINT_EN is defined.
module core_debug_ctrl #(
  parameter int N_CH         = 16,
  parameter int W            = 32,
  parameter int DISP_W       = 16,
  parameter int CNT_W        = 32,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   probe_bus,
  input  logic [W-1:0]        pc,
  input  logic [5:0]          sel,
  input  logic                run_btn,
  input  logic                step_btn,
  input  logic                halt_req,
  input  logic [W-1:0]        bp_addr,
  input  logic                bp_en,
  output logic                core_en,
  output logic [DISP_W-1:0]   disp,
  output logic [1:0]          dbg_state,
  output logic [CNT_W-1:0]    instr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  localparam state_t RESET_STATE = state_t'(START_HALTED ? 2'b01 : 2'b00);

  state_t              state_r;
  logic [N_CH*W-1:0]   snapshot_r;
  logic [N_CH*W-1:0]   probe_src_s;
  logic [DISP_W-1:0]   disp_s;
  logic [DISP_W-1:0]   disp_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                run_q_r;
  logic                step_q_r;
  logic                run_edge_s;
  logic                step_edge_s;
  logic                bp_hit_s;
  logic                unused_src_s;

  assign run_edge_s  = run_btn & ~run_q_r;
  assign step_edge_s = step_btn & ~step_q_r;

`ifdef DBG_BREAKPOINT_EN
  // bp_mask lets a resumed core execute the breakpointed instruction exactly once.
  logic bp_mask_r;
  assign bp_hit_s = bp_en & (pc == bp_addr) & ~bp_mask_r;

  // Breakpoint mask: armed on every exit from HALT, cleared after the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_mask_r <= 1'b1;
    end else if ((state_r == ST_HALT) && (run_edge_s || step_edge_s)) begin
      bp_mask_r <= 1'b1;
    end else if (state_r == ST_RUN) begin
      bp_mask_r <= 1'b0;
    end else begin
      bp_mask_r <= bp_mask_r;
    end
  end
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_en, bp_addr};
  assign bp_hit_s    = 1'b0;
`endif

  assign core_en   = ((state_r == ST_RUN) & ~halt_req & ~bp_hit_s) | (state_r == ST_STEP);
  assign dbg_state = state_r;
  assign disp      = disp_r;
  assign instr_cnt = cnt_r;

  // Button edge detectors: one history register per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q_r  <= 1'b0;
      step_q_r <= 1'b0;
    end else begin
      run_q_r  <= run_btn;
      step_q_r <= step_btn;
    end
  end

  // Debug FSM; the snapshot captures the probes of the last cycle before HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RESET_STATE;
      snapshot_r <= '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_req || bp_hit_s) begin
            state_r    <= ST_HALT;
            snapshot_r <= probe_bus;
          end else begin
            state_r    <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (step_edge_s) begin
            state_r <= ST_STEP;
          end else if (run_edge_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_HALT;
          end
        end
        ST_STEP: begin
          state_r    <= ST_HALT;
          snapshot_r <= probe_bus;
        end
        default: begin
          state_r <= RESET_STATE;
        end
      endcase
    end
  end

  assign probe_src_s  = (state_r == ST_HALT) ? snapshot_r : probe_bus;
  assign unused_src_s = ^probe_src_s;

  // Display mux: unmatched selects (sel >= N_CH) leave the default of zero.
  always_comb begin
    disp_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      disp_s = (sel == 6'(k)) ? probe_src_s[k*W +: DISP_W] : disp_s;
    end
  end

  // Registered display word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_r <= '0;
    end else begin
      disp_r <= disp_s;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (core_en && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Directed self-checking bench for core_debug_ctrl: one RUN-reset and one HALT-reset instance share stimulus.
module tb_core_debug_ctrl;
  localparam int N_CH = 4, W = 16, DISP_W = 8, CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_CH*W-1:0]   probe_bus;
  logic [W-1:0]        pc, bp_addr;
  logic [5:0]          sel;
  logic                run_btn, step_btn, halt_req, bp_en;
  logic                core_en, core_en_h;
  logic [DISP_W-1:0]   disp, disp_h;
  logic [1:0]          dbg_state, dbg_state_h;
  logic [CNT_W-1:0]    instr_cnt, instr_cnt_h;
  int                  cmp_cnt = 0;
  int                  err_cnt = 0;

  always #5 clk = ~clk;

  core_debug_ctrl #(.N_CH(N_CH), .W(W), .DISP_W(DISP_W), .CNT_W(CNT_W), .START_HALTED(1'b0)) dut (
    .clk(clk), .rst(rst), .probe_bus(probe_bus), .pc(pc), .sel(sel),
    .run_btn(run_btn), .step_btn(step_btn), .halt_req(halt_req),
    .bp_addr(bp_addr), .bp_en(bp_en),
    .core_en(core_en), .disp(disp), .dbg_state(dbg_state), .instr_cnt(instr_cnt));

  core_debug_ctrl #(.N_CH(N_CH), .W(W), .DISP_W(DISP_W), .CNT_W(CNT_W), .START_HALTED(1'b1)) dut_h (
    .clk(clk), .rst(rst), .probe_bus(probe_bus), .pc(pc), .sel(sel),
    .run_btn(run_btn), .step_btn(step_btn), .halt_req(halt_req),
    .bp_addr(bp_addr), .bp_en(bp_en),
    .core_en(core_en_h), .disp(disp_h), .dbg_state(dbg_state_h), .instr_cnt(instr_cnt_h));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run_btn = 1'b0; step_btn = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
    bp_addr = 16'h0000; pc = 16'h0000; sel = 6'd0; probe_bus = 64'h0;
    #1;
    cmp_cnt++; if (dbg_state !== 2'b00) begin err_cnt++; $display("FAIL rst_state: got %0h expected 0", dbg_state); end
    cmp_cnt++; if (core_en !== 1'b1) begin err_cnt++; $display("FAIL rst_core_en: got %0h expected 1", core_en); end
    cmp_cnt++; if (disp !== 8'h00) begin err_cnt++; $display("FAIL rst_disp: got %0h expected 0", disp); end
    cmp_cnt++; if (dbg_state_h !== 2'b01) begin err_cnt++; $display("FAIL rst_state_halted: got %0h expected 1", dbg_state_h); end
    cmp_cnt++; if (core_en_h !== 1'b0) begin err_cnt++; $display("FAIL rst_core_en_halted: got %0h expected 0", core_en_h); end
    tick();
    rst = 1'b0;
    cmp_cnt++; if (instr_cnt !== 4'h0) begin err_cnt++; $display("FAIL rst_cnt: got %0h expected 0", instr_cnt); end
    tick();
    cmp_cnt++; if (instr_cnt !== 4'h1) begin err_cnt++; $display("FAIL cnt_first: got %0h expected 1", instr_cnt); end
    tick();
    cmp_cnt++; if (instr_cnt !== 4'h2) begin err_cnt++; $display("FAIL cnt_second: got %0h expected 2", instr_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) tick();
    cmp_cnt++; if (instr_cnt !== 4'hF) begin err_cnt++; $display("FAIL cnt_saturate: got %0h expected f", instr_cnt); end
  endtask

  task automatic test_disp();
    probe_bus = {16'hD4C3, 16'hB2A1, 16'h9080, 16'h7060};
    sel = 6'd2;
    tick();
    cmp_cnt++; if (disp !== 8'hA1) begin err_cnt++; $display("FAIL disp_ch2: got %0h expected a1", disp); end
    sel = 6'd4;
    #1;
    cmp_cnt++; if (disp !== 8'hA1) begin err_cnt++; $display("FAIL disp_latency: got %0h expected a1", disp); end
    tick();
    cmp_cnt++; if (disp !== 8'h00) begin err_cnt++; $display("FAIL disp_sel_nch: got %0h expected 0", disp); end
    sel = 6'd0;
    tick();
    cmp_cnt++; if (disp !== 8'h60) begin err_cnt++; $display("FAIL disp_ch0: got %0h expected 60", disp); end
    sel = 6'd63;
    tick();
    cmp_cnt++; if (disp !== 8'h00) begin err_cnt++; $display("FAIL disp_sel63: got %0h expected 0", disp); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    tick();
    probe_bus = {16'h0F0E, 16'h0D0C, 16'h0B0A, 16'h0908};
    halt_req = 1'b1;
    #1;
    cmp_cnt++; if (core_en !== 1'b0) begin err_cnt++; $display("FAIL halt_core_en: got %0h expected 0", core_en); end
    tick();
    cmp_cnt++; if (dbg_state !== 2'b01) begin err_cnt++; $display("FAIL halt_state: got %0h expected 1", dbg_state); end
    cmp_cnt++; if (instr_cnt !== 4'h2) begin err_cnt++; $display("FAIL halt_no_commit: got %0h expected 2", instr_cnt); end
    probe_bus = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
    halt_req = 1'b0;
    sel = 6'd1;
    tick();
    cmp_cnt++; if (disp !== 8'h0A) begin err_cnt++; $display("FAIL halt_snapshot: got %0h expected 0a", disp); end
    cmp_cnt++; if (instr_cnt !== 4'h2) begin err_cnt++; $display("FAIL halt_hold_cnt: got %0h expected 2", instr_cnt); end
  endtask

  task automatic test_step();
    step_btn = 1'b1;
    tick();
    cmp_cnt++; if (dbg_state !== 2'b10) begin err_cnt++; $display("FAIL step_state: got %0h expected 2", dbg_state); end
    cmp_cnt++; if (core_en !== 1'b1) begin err_cnt++; $display("FAIL step_core_en: got %0h expected 1", core_en); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    cmp_cnt++; if (dbg_state !== 2'b01) begin err_cnt++; $display("FAIL step_back_halt: got %0h expected 1", dbg_state); end
    cmp_cnt++; if (instr_cnt !== 4'h3) begin err_cnt++; $display("FAIL step_commit: got %0h expected 3", instr_cnt); end
    tick();
    cmp_cnt++; if (instr_cnt !== 4'h3) begin err_cnt++; $display("FAIL step_once: got %0h expected 3", instr_cnt); end
    step_btn = 1'b0;
    tick();
    run_btn = 1'b1; step_btn = 1'b1;
    tick();
    cmp_cnt++; if (dbg_state !== 2'b10) begin err_cnt++; $display("FAIL step_wins: got %0h expected 2", dbg_state); end
    tick();
    run_btn = 1'b0; step_btn = 1'b0;
    tick();
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    cmp_cnt++; if (dbg_state !== 2'b00) begin err_cnt++; $display("FAIL run_resume: got %0h expected 0", dbg_state); end
    cmp_cnt++; if (core_en !== 1'b1) begin err_cnt++; $display("FAIL run_core_en: got %0h expected 1", core_en); end
  endtask

  task automatic test_discard();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0; run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    tick();
    cmp_cnt++; if (dbg_state !== 2'b00) begin err_cnt++; $display("FAIL discard_run: got %0h expected 0", dbg_state); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    tick();
    cmp_cnt++; if (dbg_state !== 2'b01) begin err_cnt++; $display("FAIL discard_queued: got %0h expected 1", dbg_state); end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    step_btn = 1'b1;
    tick();
    cmp_cnt++; if (dbg_state_h !== 2'b10) begin err_cnt++; $display("FAIL mid_step_enter: got %0h expected 2", dbg_state_h); end
    rst = 1'b1;
    #1;
    cmp_cnt++; if (dbg_state_h !== 2'b01) begin err_cnt++; $display("FAIL mid_step_state: got %0h expected 1", dbg_state_h); end
    cmp_cnt++; if (core_en_h !== 1'b0) begin err_cnt++; $display("FAIL mid_step_core_en: got %0h expected 0", core_en_h); end
    cmp_cnt++; if ({disp_h, instr_cnt_h} !== 12'h000) begin err_cnt++; $display("FAIL mid_step_outs: got %0h expected 0", {disp_h, instr_cnt_h}); end
    tick();
    step_btn = 1'b0;
    rst = 1'b0;
    tick();
    cmp_cnt++; if (instr_cnt_h !== 4'h0) begin err_cnt++; $display("FAIL mid_step_no_commit: got %0h expected 0", instr_cnt_h); end
    cmp_cnt++; if (dbg_state_h !== 2'b01) begin err_cnt++; $display("FAIL mid_step_abandon: got %0h expected 1", dbg_state_h); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    pc = 16'h001C; bp_addr = 16'h0020; bp_en = 1'b1; sel = 6'd3;
    tick();
    pc = 16'h0020;
    probe_bus = {16'h4433, 16'h2211, 16'h6655, 16'h8877};
    #1;
`ifdef DBG_BREAKPOINT_EN
    cmp_cnt++; if (core_en !== 1'b0) begin err_cnt++; $display("FAIL bp_core_en: got %0h expected 0", core_en); end
    tick();
    probe_bus = 64'h0;
    cmp_cnt++; if (dbg_state !== 2'b01) begin err_cnt++; $display("FAIL bp_halt: got %0h expected 1", dbg_state); end
    cmp_cnt++; if (instr_cnt !== 4'h1) begin err_cnt++; $display("FAIL bp_no_commit: got %0h expected 1", instr_cnt); end
    tick();
    cmp_cnt++; if (disp !== 8'h33) begin err_cnt++; $display("FAIL bp_snapshot: got %0h expected 33", disp); end
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    cmp_cnt++; if (core_en !== 1'b1) begin err_cnt++; $display("FAIL bp_resume_once: got %0h expected 1", core_en); end
    tick();
    pc = 16'h0024;
    cmp_cnt++; if (instr_cnt !== 4'h2) begin err_cnt++; $display("FAIL bp_commit: got %0h expected 2", instr_cnt); end
    tick();
    pc = 16'h0020;
    #1;
    cmp_cnt++; if (core_en !== 1'b0) begin err_cnt++; $display("FAIL bp_revisit: got %0h expected 0", core_en); end
    tick();
    cmp_cnt++; if (dbg_state !== 2'b01) begin err_cnt++; $display("FAIL bp_rehalt: got %0h expected 1", dbg_state); end
`else
    cmp_cnt++; if (core_en !== 1'b1) begin err_cnt++; $display("FAIL bp_ignored_en: got %0h expected 1", core_en); end
    tick();
    cmp_cnt++; if (dbg_state !== 2'b00) begin err_cnt++; $display("FAIL bp_ignored_state: got %0h expected 0", dbg_state); end
    cmp_cnt++; if (instr_cnt !== 4'h2) begin err_cnt++; $display("FAIL bp_ignored_cnt: got %0h expected 2", instr_cnt); end
`endif
    bp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_disp();
    test_halt();
    test_step();
    test_discard();
    test_reset_mid_step();
    test_breakpoint();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
